// File: rtl/sys_cont_pkg.sv
// Shared definitions for the system controller command and response paths.
package sys_cont_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OFFER   = 2'd1,
      WAIT_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   typedef enum logic {
      RESP_RD  = 1'b0,
      RESP_ALU = 1'b1
   } resp_t;

   // Frame opcodes, common with the command decoder
   localparam logic [7:0] OP_WRITE   = 8'hAA;
   localparam logic [7:0] OP_READ    = 8'hBB;
   localparam logic [7:0] OP_ALU_OP  = 8'hCC;
   localparam logic [7:0] OP_ALU_NOP = 8'hDD;

endpackage

// File: rtl/sys_resp_slot.sv
// One-entry result holding register with full flag.
module sys_resp_slot
   import sys_cont_pkg::*;
#(
   parameter int W = WIDTH_DEF
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           load_i,
   input  logic           pop_i,
   input  logic [2*W-1:0] data_i,
   input  resp_t          type_i,
   output logic           full_o,
   output logic [2*W-1:0] data_o,
   output resp_t          type_o
);

   logic           full_q, full_d;
   logic [2*W-1:0] data_q;
   resp_t          type_q;

   // A load in the same cycle as a pop refills the slot
   assign full_d = load_i | (full_q & ~pop_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         full_q <= 1'b0;
         data_q <= '0;
         type_q <= RESP_RD;
      end else begin
         full_q <= full_d;
         if (load_i) begin
            data_q <= data_i;
            type_q <= type_i;
         end
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;
   assign type_o = type_q;

endmodule

// File: rtl/sys_cont_tx_fsm.sv
// Response-path controller: serialises read and ALU results into UART TX.
module sys_cont_tx_fsm
   import sys_cont_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clck,
   input  logic               rst,
   input  logic [WIDTH-1:0]   rd_data,
   input  logic               rd_data_valid,
   input  logic [2*WIDTH-1:0] alu_out,
   input  logic               alu_out_valid,
   input  logic               tx_busy,
   output logic [WIDTH-1:0]   tx_p_data,
   output logic               tx_data_valid,
   output logic               resp_busy,
   output logic               overrun,
   input  logic               overrun_clr
);

   localparam int RW = 2 * WIDTH;

   state_t           state_q, state_d;
   logic [RW-1:0]    data_q, data_d;
   resp_t            type_q, type_d;
   logic             idx_q, idx_d;
   logic [WIDTH-1:0] txd_q, txd_d;
   logic             txv_q, txv_d;
   logic             busy_q;
   logic             ovr_q, ovr_d;

   logic             slot_full, slot_load, slot_pop;
   logic [RW-1:0]    slot_dout, slot_din, act_din, rd_ext;
   resp_t            slot_tout, slot_tin, act_tin;
   logic             take, drop, free, hi_next;

   assign rd_ext  = {{WIDTH{1'b0}}, rd_data};
   assign hi_next = (type_q == RESP_ALU) && !idx_q;
   assign free    = (state_q == IDLE) ||
                    (state_q == WAIT_LO && !tx_busy && !hi_next);

   // Priority when the active register frees: pending, then ALU, then read
   always_comb begin
      take      = 1'b0;
      drop      = 1'b0;
      slot_load = 1'b0;
      slot_pop  = 1'b0;
      act_din   = '0;
      act_tin   = RESP_RD;
      slot_din  = '0;
      slot_tin  = RESP_RD;
      if (free) begin
         if (slot_full) begin
            take     = 1'b1;
            slot_pop = 1'b1;
            act_din  = slot_dout;
            act_tin  = slot_tout;
            if (alu_out_valid) begin
               slot_load = 1'b1;
               slot_din  = alu_out;
               slot_tin  = RESP_ALU;
               drop      = rd_data_valid;
            end else if (rd_data_valid) begin
               slot_load = 1'b1;
               slot_din  = rd_ext;
            end
         end else if (alu_out_valid) begin
            take    = 1'b1;
            act_din = alu_out;
            act_tin = RESP_ALU;
            if (rd_data_valid) begin
               slot_load = 1'b1;
               slot_din  = rd_ext;
            end
         end else if (rd_data_valid) begin
            take    = 1'b1;
            act_din = rd_ext;
         end
      end else if (!slot_full) begin
         if (alu_out_valid) begin
            slot_load = 1'b1;
            slot_din  = alu_out;
            slot_tin  = RESP_ALU;
            drop      = rd_data_valid;
         end else if (rd_data_valid) begin
            slot_load = 1'b1;
            slot_din  = rd_ext;
         end
      end else begin
         drop = alu_out_valid | rd_data_valid;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      type_d  = type_q;
      idx_d   = idx_q;
      txd_d   = txd_q;
      txv_d   = txv_q;
      unique case (state_q)
         IDLE: begin
            if (take) begin
               state_d = OFFER;
               data_d  = act_din;
               type_d  = act_tin;
               idx_d   = 1'b0;
               txd_d   = act_din[WIDTH-1:0];
               txv_d   = 1'b1;
            end
         end
         OFFER: begin
            if (txv_q && !tx_busy) begin
               state_d = WAIT_HI;
               txv_d   = 1'b0;
            end
         end
         WAIT_HI: begin
            if (tx_busy) state_d = WAIT_LO;
         end
         WAIT_LO: begin
            if (!tx_busy) begin
               if (hi_next) begin
                  state_d = OFFER;
                  idx_d   = 1'b1;
                  txd_d   = data_q[RW-1:WIDTH];
                  txv_d   = 1'b1;
               end else if (take) begin
                  state_d = OFFER;
                  data_d  = act_din;
                  type_d  = act_tin;
                  idx_d   = 1'b0;
                  txd_d   = act_din[WIDTH-1:0];
                  txv_d   = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign ovr_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : ovr_q);

   always_ff @(posedge clck or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         type_q  <= RESP_RD;
         idx_q   <= 1'b0;
         txd_q   <= '0;
         txv_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         type_q  <= type_d;
         idx_q   <= idx_d;
         txd_q   <= txd_d;
         txv_q   <= txv_d;
         busy_q  <= (state_d != IDLE);
         ovr_q   <= ovr_d;
      end
   end

   sys_resp_slot #(.W(WIDTH)) u_pend (
      .clk_i  (clck),
      .rst_i  (rst),
      .load_i (slot_load),
      .pop_i  (slot_pop),
      .data_i (slot_din),
      .type_i (slot_tin),
      .full_o (slot_full),
      .data_o (slot_dout),
      .type_o (slot_tout)
   );

   assign tx_p_data     = txd_q;
   assign tx_data_valid = txv_q;
   assign resp_busy     = busy_q;
   assign overrun       = ovr_q;

endmodule

// File: tb/tb_sys_cont_tx_fsm.sv
// Scoreboard bench for sys_cont_tx_fsm with a simple UART TX busy model.
module tb_sys_cont_tx_fsm;

   logic        clck = 1'b0;
   logic        rst;
   logic [7:0]  rd_data;
   logic        rd_data_valid;
   logic [15:0] alu_out;
   logic        alu_out_valid;
   logic        tx_busy;
   logic [7:0]  tx_p_data;
   logic        tx_data_valid;
   logic        resp_busy;
   logic        overrun;
   logic        overrun_clr;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   int         acc_t[$];
   int         n_acc = 0;
   int         last_len = 0;
   int         cyc = 0;
   int         cnt = 0;
   logic       ext_busy = 1'b0;

   always #5 clck = ~clck;

   sys_cont_tx_fsm dut (
      .clck          (clck),
      .rst           (rst),
      .rd_data       (rd_data),
      .rd_data_valid (rd_data_valid),
      .alu_out       (alu_out),
      .alu_out_valid (alu_out_valid),
      .tx_busy       (tx_busy),
      .tx_p_data     (tx_p_data),
      .tx_data_valid (tx_data_valid),
      .resp_busy     (resp_busy),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr)
   );

   // UART TX model: busy for 10 cycles after each accepted byte
   assign tx_busy = ext_busy || (cnt != 0);

   initial forever begin
      @(posedge clck);
      cyc <= cyc + 1;
      if (tx_data_valid && !tx_busy) cnt <= 10;
      else if (cnt != 0) cnt <= cnt - 1;
   end

   // Monitor: an accept happens at the edge following this sample
   initial begin
      logic       pv, pa, acc;
      logic [7:0] pd, e;
      int         vlen;
      pv = 1'b0; pa = 1'b0; pd = '0; vlen = 0;
      forever begin
         @(negedge clck);
         if (rst) begin
            pv = 1'b0;
            vlen = 0;
         end else begin
            if (pv && !pa) begin
               checks++;
               if (!(tx_data_valid && tx_p_data == pd)) begin
                  errors++;
                  $display("FAIL hold: valid=%0b data=%02h required valid=1 data=%02h",
                           tx_data_valid, tx_p_data, pd);
               end
            end
            if (tx_data_valid) vlen++;
            acc = tx_data_valid && !tx_busy;
            if (acc) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL byte: got %02h, required none", tx_p_data);
               end else begin
                  e = exp_q.pop_front();
                  if (tx_p_data !== e) begin
                     errors++;
                     $display("FAIL byte: got %02h required %02h", tx_p_data, e);
                  end
               end
               last_len = vlen;
               vlen = 0;
               acc_t.push_back(cyc);
               n_acc++;
            end
            pv = tx_data_valid;
            pa = acc;
            pd = tx_p_data;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clck);
      #2;
   endtask

   task automatic strobe(input logic rv, input logic [7:0] rd,
                         input logic av, input logic [15:0] alu);
      tick();
      rd_data_valid = rv;
      rd_data       = rd;
      alu_out_valid = av;
      alu_out       = alu;
      tick();
      rd_data_valid = 1'b0;
      alu_out_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clck);
         if (!resp_busy && exp_q.size() == 0) done = 1'b1;
      end
      chk({name, " idle"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      int n0;
      rst = 1'b1;
      rd_data = '0; rd_data_valid = 1'b0;
      alu_out = '0; alu_out_valid = 1'b0;
      overrun_clr = 1'b0;
      #1;
      chk("rst valid", {31'd0, tx_data_valid}, 32'd0);
      chk("rst data", {24'd0, tx_p_data}, 32'd0);
      chk("rst busy", {31'd0, resp_busy}, 32'd0);
      chk("rst ovr", {31'd0, overrun}, 32'd0);
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // single read byte, 1-cycle latency
      n0 = n_acc;
      exp_q.push_back(8'h5A);
      strobe(1'b1, 8'h5A, 1'b0, 16'h0);
      chk("rd latency", {31'd0, tx_data_valid}, 32'd1);
      chk("rd data", {24'd0, tx_p_data}, 32'h5A);
      chk("rd busy", {31'd0, resp_busy}, 32'd1);
      wait_idle("rd");
      chk("rd vlen", last_len, 32'd1);
      chk("rd accepts", n_acc - n0, 32'd1);
      chk("rd txbusy at idle", {31'd0, tx_busy}, 32'd0);

      // ALU result, low byte first, second offer after busy low
      n0 = n_acc;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      strobe(1'b0, 8'h0, 1'b1, 16'h1234);
      chk("alu lo data", {24'd0, tx_p_data}, 32'h34);
      wait_idle("alu");
      chk("alu accepts", n_acc - n0, 32'd2);
      chk("alu gap", acc_t[acc_t.size()-1] - acc_t[acc_t.size()-2], 32'd12);

      // back-pressure
      n0 = n_acc;
      tick();
      ext_busy = 1'b1;
      exp_q.push_back(8'h5A);
      strobe(1'b1, 8'h5A, 1'b0, 16'h0);
      repeat (20) @(negedge clck);
      chk("bp valid", {31'd0, tx_data_valid}, 32'd1);
      chk("bp data", {24'd0, tx_p_data}, 32'h5A);
      chk("bp accepts held", n_acc - n0, 32'd0);
      tick();
      ext_busy = 1'b0;
      wait_idle("bp");
      chk("bp accepts", n_acc - n0, 32'd1);

      // simultaneous strobes in IDLE
      n0 = n_acc;
      exp_q.push_back(8'hEF);
      exp_q.push_back(8'hBE);
      exp_q.push_back(8'h07);
      strobe(1'b1, 8'h07, 1'b1, 16'hBEEF);
      wait_idle("sim");
      chk("sim accepts", n_acc - n0, 32'd3);
      chk("sim ovr", {31'd0, overrun}, 32'd0);

      // overflow of the pending slot
      n0 = n_acc;
      exp_q.push_back(8'hCD);
      exp_q.push_back(8'hAB);
      exp_q.push_back(8'h01);
      strobe(1'b0, 8'h0, 1'b1, 16'hABCD);
      strobe(1'b1, 8'h01, 1'b0, 16'h0);
      chk("ovf ovr after 1st", {31'd0, overrun}, 32'd0);
      strobe(1'b1, 8'h02, 1'b0, 16'h0);
      chk("ovf ovr set", {31'd0, overrun}, 32'd1);
      wait_idle("ovf");
      chk("ovf accepts", n_acc - n0, 32'd3);
      chk("ovf ovr sticky", {31'd0, overrun}, 32'd1);
      tick();
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      chk("ovf ovr clr", {31'd0, overrun}, 32'd0);

      // reset during WAIT_LO of ALU byte 0
      n0 = n_acc;
      exp_q.push_back(8'h66);
      strobe(1'b0, 8'h0, 1'b1, 16'h5566);
      for (int i = 0; i < 50 && n_acc == n0; i++) @(negedge clck);
      chk("mid accept seen", n_acc - n0, 32'd1);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("mid rst valid", {31'd0, tx_data_valid}, 32'd0);
      chk("mid rst data", {24'd0, tx_p_data}, 32'd0);
      chk("mid rst busy", {31'd0, resp_busy}, 32'd0);
      tick();
      rst = 1'b0;
      repeat (40) @(negedge clck);
      chk("mid no hi byte", n_acc - n0, 32'd1);
      chk("mid idle", {31'd0, resp_busy}, 32'd0);

      chk("queue empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
